alu_fu: RTL and testbench
=========================

Name: alu_fu

Overview:
- Integer ALU functional unit: the consumer end of the reservation-station issue interface and the producer end of the CDB wakeup broadcast (ps_in/ps_ready).
- Requests work from res_station via fu_ready and accepts an rs_data beat on fu_dispatched.
- Reads operands from the PRF, executes, and buffers results in an in-order output queue.
- Broadcasts pd, result and rob_index on the CDB when granted. Squashes wrong-path work on mispredict.

Parameters:
OUT_DEPTH, 4, output-queue entries; also the occupancy bound for fu_ready
XLEN, 32, datapath width

Ports:
clk  in  1  clock
reset  in  1  reset
fu_ready  out  1  request one instruction from the RS
fu_dispatched  in  1  RS issued an instruction to this unit
data_in  in  rs_data  issued entry (ps1, ps2, pd, rob_index, Opcode, func3, func7, imm)
prf_raddr1  out  7  PRF read address, driven from data_in.ps1
prf_raddr2  out  7  PRF read address, driven from data_in.ps2
prf_rdata1  in  XLEN  PRF data, combinational same cycle
prf_rdata2  in  XLEN  PRF data, combinational same cycle
rob_head  in  5  oldest ROB index, used for age compare
mispredict  in  1  squash request
mispredict_tag  in  5  ROB index of the mispredicted branch
cdb_grant  in  1  CDB arbiter accepts the current broadcast
ps_out  out  7  broadcast physical destination; connects to RS ps_in
ps_ready  out  1  broadcast valid
result  out  XLEN  broadcast value
result_rob_index  out  5  ROB entry completed

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Reset: while reset=1 and at the edge after, fu_ready=0, ps_ready=0, ps_out=0, result=0, result_rob_index=0. Ex stage, queue and req_pending are cleared. Reset mid-operation discards all in-flight work with no broadcast.
- Request protocol: req_pending is a flop that registers fu_ready. fu_ready = (ex_valid + outq_count + req_pending) < OUT_DEPTH (combinational). The RS answers a request one cycle later. fu_dispatched must always be accepted, so the bound guarantees space. Back-to-back requests are allowed.
- fu_dispatched with req_pending=0 is a protocol error: accept it and flag an assertion.
- Capture: at the posedge where fu_dispatched=1, latch the ALU result, pd and rob_index into the ex stage. Operands are read combinationally through prf_raddr1/2.
- Ex to queue: on the next posedge the ex stage is pushed to the queue tail (space is guaranteed).
- Broadcast latency: ps_ready rises in the second cycle after the capture edge when the queue was empty.
- Broadcast: ps_ready=1 whenever the queue head is valid and not squashed. ps_out, result and result_rob_index hold stable until cdb_grant is sampled 1, then the head pops. cdb_grant is ignored while ps_ready=0.
- Queue order: push and pop in the same cycle are allowed, with occupancy unchanged. Results are strictly FIFO.
- Opcode 0110011 (R-type) decodes by func3/func7: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- Opcode 0010011 (I-type) uses imm[31:0] as the second operand. SRAI/SRLI are selected by imm[10].
- Opcode 0110111 (LUI): result = imm[31:0].
- Any other opcode: result 0, still broadcast. Shift amounts use the low 5 bits. Arithmetic wraps mod 2^XLEN.
- Age compare (mod 32): entry e is younger than the tag iff (e.rob_index − rob_head) > (mispredict_tag − rob_head). Wrap-around must work.
- Mispredict, all in the same edge:
  - drop the ex stage if younger;
  - drop an incoming fu_dispatched if younger;
  - mark younger queue entries squashed;
  - the branch itself and older entries survive.
- Squashed queue entries: a squashed head pops on the next edge without raising ps_ready and without needing a grant. Squashed entries count toward occupancy until popped.
- Mispredict and cdb_grant in the same cycle: the grant applies to the head only if the head is not squashed by that mispredict. A head younger than the tag is squashed, and its broadcast is not counted as delivered.

Decomposition:
- types_pkg:
  - fu_result_t (valid, squashed, pd[6:0], rob_index[4:0], value[XLEN-1:0]);
  - opcode constants OP_R=0110011, OP_I=0010011, OP_LUI=0110111;
  - func3 constants;
  - function rob_younger(idx, tag, head).
- One sub-module, alu_core: purely combinational (opcode, func3, func7, a, b, imm) → result.
- The queue lives in alu_fu.

Test Plan:
- ADD: preload prf[10]=5, prf[11]=7; dispatch ps1=10 ps2=11 pd=20 rob=3; cdb_grant=1 → ps_ready for exactly one cycle with ps_out=20, result=12, result_rob_index=3, two cycles after capture.
- I-type/shift:
  - ADDI with prf[12]=0xFFFFFFFF, imm=1 → result 0.
  - SRAI with prf[12]=0x80000000, imm=0x404 → result 0xF8000000.
- Back-pressure: cdb_grant=0, keep requesting → at most 4 instructions accepted, fu_ready=0 thereafter. Release the grant for 1 cycle → fu_ready reasserts. Broadcasts follow dispatch order and none are lost.
- Mispredict: rob_head=0, queued rob 3,5,6, mispredict_tag=4 → only rob 3 broadcasts. Then two squashed pops with no ps_ready, and occupancy returns to 0.
- Wrap-around: rob_head=30, entries rob 30 and rob 1, mispredict_tag=31 → rob 30 broadcast, rob 1 squashed.
- Reset mid-operation: 3 queued entries, reset 1 cycle → no ps_ready after, fu_ready=0 during reset, fu_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared types, opcode/func3 constants and ROB age helper for the ALU unit
package types_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [6:0]  ps1;
        logic [6:0]  ps2;
        logic [6:0]  pd;
        logic [4:0]  rob_index;
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [31:0] imm;
    } rs_data_t;

    typedef struct packed {
        logic            valid;
        logic            squashed;
        logic [6:0]      pd;
        logic [4:0]      rob_index;
        logic [XLEN-1:0] value;
    } fu_result_t;

    // Distances from the ROB head are taken mod 32 so the compare survives wrap-around.
    function automatic logic rob_younger(input logic [4:0] idx,
                                         input logic [4:0] tag,
                                         input logic [4:0] head);
        logic [4:0] d_idx;
        logic [4:0] d_tag;
        d_idx = idx - head;
        d_tag = tag - head;
        return d_idx > d_tag;
    endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational integer ALU decode and execute
// Ports:
//   opcode_i, func3_i, func7_i : instruction decode fields
//   a_i, b_i                   : register operands
//   imm_i                      : immediate (second operand for I-type, value for LUI)
//   result_o                   : computed result, 0 for unsupported opcodes
module alu_core
    import types_pkg::*;
(
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      func3_i,
    input  logic [6:0]      func7_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [31:0]     imm_i,
    output logic [XLEN-1:0] result_o
);

    logic [XLEN-1:0] op_b;
    logic [4:0]      shamt;
    logic            is_r;
    logic            arith_shift;

    always_comb begin
        is_r        = (opcode_i == OP_R);
        op_b        = is_r ? b_i : imm_i;
        shamt       = op_b[4:0];
        // I-type shifts carry the arithmetic select inside the immediate.
        arith_shift = is_r ? (func7_i == F7_ALT) : imm_i[10];
        result_o    = '0;
        if (opcode_i == OP_LUI) begin
            result_o = imm_i;
        end else if (is_r || opcode_i == OP_I) begin
            case (func3_i)
                F3_ADD:  result_o = (is_r && func7_i == F7_ALT) ? a_i - op_b : a_i + op_b;
                F3_SLL:  result_o = a_i << shamt;
                F3_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(op_b))};
                F3_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < op_b)};
                F3_XOR:  result_o = a_i ^ op_b;
                F3_SR:   result_o = arith_shift ? $unsigned($signed(a_i) >>> shamt) : (a_i >> shamt);
                F3_OR:   result_o = a_i | op_b;
                default: result_o = a_i & op_b;
            endcase
        end
    end

endmodule

// File: rtl/alu_fu.sv
// rtl/alu_fu.sv - ALU functional unit: RS issue consumer, execute stage, in-order CDB output queue
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   fu_ready / fu_dispatched   : request to RS / RS issue strobe with data_in
//   prf_raddr1/2, prf_rdata1/2 : combinational PRF operand read
//   rob_head, mispredict, mispredict_tag : squash control
//   cdb_grant                  : broadcast accepted
//   ps_out, ps_ready, result, result_rob_index : CDB broadcast
module alu_fu
    import types_pkg::*;
#(
    parameter int OUT_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            fu_ready,
    input  logic            fu_dispatched,
    input  rs_data_t        data_in,
    output logic [6:0]      prf_raddr1,
    output logic [6:0]      prf_raddr2,
    input  logic [XLEN-1:0] prf_rdata1,
    input  logic [XLEN-1:0] prf_rdata2,
    input  logic [4:0]      rob_head,
    input  logic            mispredict,
    input  logic [4:0]      mispredict_tag,
    input  logic            cdb_grant,
    output logic [6:0]      ps_out,
    output logic            ps_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      result_rob_index
);

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    fu_result_t       q_mem_q [OUT_DEPTH];
    fu_result_t       q_mem_d [OUT_DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    fu_result_t       ex_q, ex_d;
    logic             req_pending_q;

    logic [XLEN-1:0]  alu_result;
    fu_result_t       head;
    logic             head_valid;
    logic             head_kill, ex_kill, in_kill;
    logic             push, pop;
    logic [OCC_W-1:0] occ;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign prf_raddr1 = data_in.ps1;
    assign prf_raddr2 = data_in.ps2;

    alu_core u_core (
        .opcode_i (data_in.opcode),
        .func3_i  (data_in.func3),
        .func7_i  (data_in.func7),
        .a_i      (prf_rdata1),
        .b_i      (prf_rdata2),
        .imm_i    (data_in.imm),
        .result_o (alu_result)
    );

    // Outstanding requests count as occupied so an answered request always finds a slot.
    assign occ      = {{CNT_W{1'b0}}, ex_q.valid} + {1'b0, count_q} + {{CNT_W{1'b0}}, req_pending_q};
    assign fu_ready = !reset && (occ < OCC_W'(OUT_DEPTH));

    assign head       = q_mem_q[head_q];
    assign head_valid = (count_q != '0) && head.valid;

    assign ps_ready         = !reset && head_valid && !head.squashed;
    assign ps_out           = ps_ready ? head.pd : '0;
    assign result           = ps_ready ? head.value : '0;
    assign result_rob_index = ps_ready ? head.rob_index : '0;

    assign head_kill = mispredict && rob_younger(head.rob_index, mispredict_tag, rob_head);
    assign ex_kill   = mispredict && rob_younger(ex_q.rob_index, mispredict_tag, rob_head);
    assign in_kill   = mispredict && rob_younger(data_in.rob_index, mispredict_tag, rob_head);

    assign push = ex_q.valid && !ex_kill;
    // A grant landing on a head squashed in the same cycle is not a delivery; the head is
    // only marked and leaves on the following edge like any squashed head.
    assign pop  = head_valid && (head.squashed || (cdb_grant && !head_kill));

    always_comb begin
        q_mem_d = q_mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (mispredict) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                if (rob_younger(q_mem_q[i].rob_index, mispredict_tag, rob_head)) begin
                    q_mem_d[i].squashed = 1'b1;
                end
            end
        end
        if (push) begin
            q_mem_d[tail_q] = ex_q;
            tail_d          = ptr_inc(tail_q);
        end
        if (pop) begin
            head_d = ptr_inc(head_q);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        ex_d    = '{valid:     fu_dispatched && !in_kill,
                    squashed:  1'b0,
                    pd:        data_in.pd,
                    rob_index: data_in.rob_index,
                    value:     alu_result};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q          <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            req_pending_q <= 1'b0;
        end else begin
            ex_q          <= ex_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            req_pending_q <= fu_ready;
        end
    end

    // Payload storage needs no reset: liveness is carried by count_q.
    always_ff @(posedge clk) begin
        q_mem_q <= q_mem_d;
    end

    a_dispatch_needs_request: assert property (@(posedge clk) disable iff (reset)
        fu_dispatched |-> req_pending_q);

endmodule

// File: tb/tb_alu_fu.sv
// tb/tb_alu_fu.sv - self-checking bench for alu_fu with RS/PRF model and result scoreboard
module tb_alu_fu;
    import types_pkg::*;

    logic            clk = 1'b0;
    logic            reset, fu_ready, fu_dispatched, mispredict, cdb_grant, ps_ready;
    rs_data_t        data_in;
    logic [6:0]      prf_raddr1, prf_raddr2, ps_out;
    logic [XLEN-1:0] prf_rdata1, prf_rdata2, result;
    logic [4:0]      rob_head, mispredict_tag, result_rob_index;

    logic [XLEN-1:0] prf [128];

    typedef struct {
        logic [6:0]      pd;
        logic [4:0]      rob;
        logic [XLEN-1:0] val;
    } exp_t;

    exp_t     exp_q[$];
    rs_data_t stim_q[$];
    int       n_cmp = 0;
    int       n_bad = 0;
    int       n_disp = 0;
    bit       rs_en = 0;
    bit       req_seen = 0;
    bit       rand_grant = 0;
    bit       grant_level = 0;

    always #5 clk = ~clk;

    assign prf_rdata1 = prf[prf_raddr1];
    assign prf_rdata2 = prf[prf_raddr2];

    alu_fu #(.OUT_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .fu_ready(fu_ready), .fu_dispatched(fu_dispatched),
        .data_in(data_in), .prf_raddr1(prf_raddr1), .prf_raddr2(prf_raddr2),
        .prf_rdata1(prf_rdata1), .prf_rdata2(prf_rdata2), .rob_head(rob_head),
        .mispredict(mispredict), .mispredict_tag(mispredict_tag), .cdb_grant(cdb_grant),
        .ps_out(ps_out), .ps_ready(ps_ready), .result(result), .result_rob_index(result_rob_index)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_alu(input rs_data_t d, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] rb);
        logic [XLEN-1:0] b;
        int sh;
        bit alt;
        if (d.opcode == OP_LUI) return d.imm;
        if (d.opcode != OP_R && d.opcode != OP_I) return '0;
        b   = (d.opcode == OP_I) ? d.imm : rb;
        sh  = int'(b % 32);
        alt = (d.opcode == OP_R) && (d.func7 == 7'h20);
        case (d.func3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? XLEN'(1) : XLEN'(0);
            3'd3: return (a < b) ? XLEN'(1) : XLEN'(0);
            3'd4: return a ^ b;
            3'd5: return ((d.opcode == OP_I) ? d.imm[10] : alt) ? $unsigned($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic bit is_younger(input logic [4:0] idx, input logic [4:0] tag, input logic [4:0] head);
        return ((int'(idx) - int'(head) + 32) % 32) > ((int'(tag) - int'(head) + 32) % 32);
    endfunction

    function automatic rs_data_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [6:0] p1, input logic [6:0] p2, input logic [6:0] pd,
                                    input logic [4:0] rob, input logic [31:0] imm);
        rs_data_t d;
        d.opcode = op; d.func3 = f3; d.func7 = f7; d.ps1 = p1; d.ps2 = p2;
        d.pd = pd; d.rob_index = rob; d.imm = imm;
        return d;
    endfunction

    // RS model: answers a request seen in the previous cycle; also drives the CDB grant.
    always @(posedge clk) begin : rs_drv
        rs_data_t d;
        #1;
        if (rs_en && req_seen && !reset && stim_q.size() > 0) begin
            d = stim_q.pop_front();
            data_in = d;
            fu_dispatched = 1'b1;
            n_disp++;
            exp_q.push_back('{d.pd, d.rob_index, ref_alu(d, prf[d.ps1], prf[d.ps2])});
        end else begin
            fu_dispatched = 1'b0;
        end
        cdb_grant = rand_grant ? ($urandom_range(0, 2) != 0) : grant_level;
    end

    // Scoreboard: every granted broadcast must match the oldest live instruction.
    always @(negedge clk) begin : monitor
        exp_t e;
        req_seen = fu_ready;
        if (reset === 1'b0 && ps_ready === 1'b1 && cdb_grant === 1'b1 && mispredict !== 1'b1) begin
            if (exp_q.size() == 0) begin
                check("bcast_unexpected", {57'd0, ps_out}, 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check("bcast_pd", ps_out, e.pd);
                check("bcast_result", result, e.val);
                check("bcast_rob", result_rob_index, e.rob);
            end
        end
    end

    task automatic wait_bcast(input string tag, input logic [6:0] pd, input logic [31:0] val, input logic [4:0] rob);
        bit seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (ps_ready === 1'b1) seen = 1;
        end
        check({tag, "_seen"}, seen, 1);
        if (seen) begin
            check({tag, "_pd"}, ps_out, pd);
            check({tag, "_result"}, result, val);
            check({tag, "_rob"}, result_rob_index, rob);
        end
    endtask

    task automatic squash(input logic [4:0] tag);
        exp_t keep[$];
        @(posedge clk); #1;
        mispredict = 1'b1;
        mispredict_tag = tag;
        foreach (exp_q[i]) if (!is_younger(exp_q[i].rob, tag, rob_head)) keep.push_back(exp_q[i]);
        exp_q = keep;
        @(negedge clk);
        grant_level = 1;
        @(posedge clk); #1;
        mispredict = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int k = 0; k < budget && (exp_q.size() + stim_q.size()) != 0; k++) @(negedge clk);
        check(tag, exp_q.size() + stim_q.size(), 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit seen;
        int base;
        reset = 1'b1; mispredict = 1'b0; mispredict_tag = '0; rob_head = '0;
        for (int i = 0; i < 128; i++) prf[i] = $urandom;
        repeat (3) @(negedge clk);
        check("rst_fu_ready", fu_ready, 0);
        check("rst_ps_ready", ps_ready, 0);
        check("rst_ps_out", ps_out, 0);
        check("rst_result", result, 0);
        check("rst_rob", result_rob_index, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_fu_ready", fu_ready, 1);
        rs_en = 1; grant_level = 1;
        repeat (2) @(negedge clk);

        // ADD with latency and one-cycle broadcast checks
        prf[10] = 5; prf[11] = 7;
        stim_q.push_back(mk(OP_R, F3_ADD, 7'h00, 10, 11, 20, 3, 0));
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (fu_dispatched === 1'b1) seen = 1;
        end
        check("add_dispatched", seen, 1);
        @(negedge clk); check("add_lat_cycle1", ps_ready, 0);
        @(negedge clk); check("add_lat_cycle2", ps_ready, 1);
        check("add_pd", ps_out, 20); check("add_result", result, 12); check("add_rob", result_rob_index, 3);
        @(negedge clk); check("add_one_cycle", ps_ready, 0);

        prf[12] = 32'hFFFF_FFFF;
        stim_q.push_back(mk(OP_I, F3_ADD, 7'h20, 12, 0, 21, 4, 32'h1));
        wait_bcast("addi", 21, 32'h0, 4);
        prf[12] = 32'h8000_0000;
        stim_q.push_back(mk(OP_I, F3_SR, 7'h00, 12, 0, 22, 5, 32'h404));
        wait_bcast("srai", 22, 32'hF800_0000, 5);
        stim_q.push_back(mk(OP_LUI, 3'd0, 7'h00, 1, 2, 23, 6, 32'hABCD_E000));
        wait_bcast("lui", 23, 32'hABCD_E000, 6);
        stim_q.push_back(mk(7'b0000011, 3'd0, 7'h00, 1, 2, 24, 7, 32'h55));
        wait_bcast("other_op", 24, 32'h0, 7);
        drain("directed_drained", 50);

        // Back-pressure: four accepted while the CDB is blocked
        grant_level = 0;
        repeat (3) @(negedge clk);
        base = n_disp;
        for (int i = 0; i < 6; i++)
            stim_q.push_back(mk(OP_R, 3'($urandom), ($urandom % 2) ? 7'h20 : 7'h00,
                                7'($urandom), 7'($urandom), 7'(40 + i), 5'(8 + i), 0));
        repeat (12) @(negedge clk);
        check("bp_accepted", n_disp - base, 4);
        check("bp_fu_ready_low", fu_ready, 0);
        grant_level = 1;
        @(negedge clk); grant_level = 0;
        @(negedge clk); check("bp_fu_ready_reassert", fu_ready, 1);
        grant_level = 1;
        drain("bp_drained", 100);
        check("bp_all_dispatched", n_disp - base, 6);

        // Mispredict: rob 3,5,6 queued, branch rob 4
        grant_level = 0; rob_head = 0;
        repeat (3) @(negedge clk);
        stim_q.push_back(mk(OP_R, F3_XOR, 7'h00, 3, 4, 50, 3, 0));
        stim_q.push_back(mk(OP_R, F3_OR, 7'h00, 5, 6, 51, 5, 0));
        stim_q.push_back(mk(OP_R, F3_AND, 7'h00, 7, 8, 52, 6, 0));
        repeat (10) @(negedge clk);
        squash(5'd4);
        @(negedge clk);
        check("mp_head_ready", ps_ready, 1); check("mp_head_rob", result_rob_index, 3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); check("mp_squashed_quiet", ps_ready, 0);
        end
        check("mp_model_empty", exp_q.size(), 0);
        check("mp_fu_ready", fu_ready, 1);

        // Wrap-around age compare
        grant_level = 0; rob_head = 30;
        repeat (3) @(negedge clk);
        stim_q.push_back(mk(OP_R, F3_SLL, 7'h00, 9, 10, 60, 30, 0));
        stim_q.push_back(mk(OP_R, F3_SLTU, 7'h00, 11, 12, 61, 1, 0));
        repeat (8) @(negedge clk);
        squash(5'd31);
        @(negedge clk);
        check("wrap_head_ready", ps_ready, 1); check("wrap_head_rob", result_rob_index, 30);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); check("wrap_squashed_quiet", ps_ready, 0);
        end
        check("wrap_model_empty", exp_q.size(), 0);

        // Reset with work in flight
        grant_level = 0; rob_head = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) stim_q.push_back(mk(OP_I, F3_ADD, 7'h00, 7'(i), 0, 7'(70 + i), 5'(i), 32'h10));
        repeat (8) @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("rst_mid_fu_ready", fu_ready, 0);
        check("rst_mid_ps_ready", ps_ready, 0);
        exp_q.delete();
        grant_level = 1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk); check("rst_mid_fu_ready_after", fu_ready, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); check("rst_mid_no_bcast", ps_ready, 0);
        end

        // Randomized traffic with random CDB back-pressure
        rand_grant = 1;
        for (int i = 0; i < 40; i++) begin
            int sel = $urandom_range(0, 5);
            logic [6:0] op;
            op = (sel < 3) ? OP_R : (sel < 5) ? OP_I : (($urandom % 2) ? OP_LUI : 7'b0000011);
            stim_q.push_back(mk(op, 3'($urandom), ($urandom % 2) ? 7'h20 : 7'h00,
                                7'($urandom), 7'($urandom), 7'($urandom), 5'(i % 32), $urandom));
        end
        drain("rand_drained", 3000);
        rand_grant = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
